pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised elastic pipeline stage: generic successor to the fixed EX/MEM latch.
//  Carries a control word and a data payload between two pipeline stages.
//  Valid/ready handshake on both sides, a 2-entry skid buffer for full throughput,
//  and a synchronous flush that inserts a bubble. Instantiated between EX and MEM,
//  and reusable at any other stage boundary.
// PARAMETERS
//  CTRL_W  16   control bits (RegWr, MemWr, dREN, dWEN, halt, ...); zeroed on reset/flush
//  DATA_W  256  payload bits (pc, rdat1/2, alu result, instr, ...); never cleared by flush
//  CNT_W   32   width of the perf counters (used only with PIPE_PERF_EN)
// PORTS
//  CLK          in   1       clock, rising edge
//  nRST         in   1       asynchronous reset, active-low
//  flush        in   1       synchronous flush; drops all held entries and the current input
//  in_valid     in   1       upstream entry valid
//  in_ready     out  1       stage can accept; registered (= !skid_valid)
//  in_ctrl      in   CTRL_W  upstream control word
//  in_data      in   DATA_W  upstream payload
//  out_valid    out  1       main entry valid
//  out_ready    in   1       downstream accepts (low = stall, e.g. waiting on dhit)
//  out_ctrl     out  CTRL_W  main control word; forced to 0 whenever out_valid=0
//  out_data     out  DATA_W  main payload; undefined-but-stable when out_valid=0
//  stall_cnt    out  CNT_W   cycles with out_valid & !out_ready (0 without PIPE_PERF_EN)
//  bubble_cnt   out  CNT_W   cycles with !out_valid (0 without PIPE_PERF_EN)
// BEHAVIOUR
//  - Two slots: MAIN (drives outputs) and SKID. acc = in_valid&in_ready; pop = out_valid&out_ready.
//  - State (pipe_state_t): EMPTY (no slot valid), ONE (MAIN valid), FULL (MAIN and SKID valid).
//  - EMPTY: acc -> ONE, MAIN<=in.
//  - ONE: acc&pop -> ONE, MAIN<=in | acc&!pop -> FULL, SKID<=in | pop&!acc -> EMPTY.
//  - FULL: in_ready=0, so acc is impossible; pop -> ONE, MAIN<=SKID; else hold.
//  - Latency: 1 cycle from acc to out_valid. Throughput: 1 entry/cycle while out_ready=1.
//  - Ordering is strictly FIFO; no entry is ever dropped or duplicated, except on flush.
//  - in_ready comes only from flops; it has no combinational path from out_ready.
//  - flush has priority over all other events. Next state is EMPTY.
//    - Both valids clear and both ctrl slots are zeroed.
//    - Data slots hold their values.
//    - An input presented in the flush cycle is discarded.
//    - A pop in the flush cycle is still counted as consumed by downstream.
//  - Reset (nRST=0, async): state EMPTY; all ctrl and data slots are 0.
//    - Reset values: out_valid=0, in_ready=1, out_ctrl=0, out_data=0, counters=0.
//  - Reset mid-operation discards every held entry. The first acc after nRST rises
//    is accepted in the first edge.
// CONFIGURATION
//  PIPE_PERF_EN defined:
//    - stall_cnt and bubble_cnt increment once per qualifying cycle.
//    - Counters saturate at all-ones and clear only on reset. Flush does not clear them.
//  PIPE_PERF_EN undefined:
//    - Counter flops are not generated; stall_cnt and bubble_cnt are tied to 0.
//    - Port list is unchanged.
// STRUCTURE
//  - Shared package pipe_pkg holds:
//    - typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t
//    - localparam PIPE_CTRL_BUBBLE = '0
//    - typedef struct packed for the EX/MEM ctrl and data word layout
//  - Sub-module pipe_slot: one ctrl+data register with valid and load enable.
//    - Async-clears on nRST; synchronous ctrl clear on flush.
//    - Instantiated twice (MAIN, SKID).
//  - Top level contains the FSM, the load selects for MAIN (in vs SKID), and the optional counters.
// TESTING
//  1. Reset: nRST=0 mid-stream with FULL state.
//     -> next cycle out_valid=0, in_ready=1, out_ctrl=0, out_data=0, counters=0.
//  2. Streaming: out_ready=1; push ctrl 0x0001..0x0008 on 8 consecutive cycles.
//     -> same 8 words out in order, 1-cycle latency, in_ready stays 1.
//  3. Stall/skid: push A, B, C with out_ready=0.
//     -> A in MAIN, B in SKID, in_ready=0 after B, C held upstream.
//     -> raise out_ready: A, B, C appear on consecutive cycles.
//  4. Flush in FULL with in_valid=1 (ctrl 0x00FF):
//     -> next cycle out_valid=0, out_ctrl=0, in_ready=1.
//     -> 0x00FF never appears on the output.
//  5. Flush and pop in the same cycle in ONE:
//     -> the popped entry is seen once by downstream; state goes EMPTY.
//  6. PIPE_PERF_EN: 5 stall cycles, 3 empty cycles -> stall_cnt=5, bubble_cnt=3.
//     -> With CNT_W=4 forced, holding a stall 20 cycles gives stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages.
//  pipe_state_t     : occupancy of a two-slot stage (EMPTY / ONE / FULL)
//  PIPE_CTRL_BUBBLE : bit value replicated across a control word to form a bubble
//  exmem_ctrl_t     : EX/MEM control word layout (16 bits)
//  exmem_data_t     : EX/MEM payload layout (256 bits)
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   localparam logic PIPE_CTRL_BUBBLE = '0;

   typedef struct packed {
      logic        reg_wr;
      logic        mem_wr;
      logic        dren;
      logic        dwen;
      logic        halt;
      logic [10:0] rsvd;
   } exmem_ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rdat1;
      logic [31:0] rdat2;
      logic [31:0] alu_res;
      logic [31:0] instr;
      logic [31:0] imm;
      logic [63:0] rsvd;
   } exmem_data_t;

   localparam int PIPE_CTRL_W = $bits(exmem_ctrl_t);
   localparam int PIPE_DATA_W = $bits(exmem_data_t);

endpackage

// File: rtl/pipe_slot.sv
// One ctrl+data holding register with a valid bit.
// Ports:
//  CLK, nRST        clock, async active-low reset (clears valid, ctrl and data)
//  flush            sync: clears valid and zeroes ctrl, data holds
//  load             capture d_ctrl/d_data and set valid
//  clr              drop valid (entry consumed), contents hold
//  d_ctrl, d_data   load values
//  valid, ctrl, data  slot contents
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              load,
   input  logic              clr,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         ctrl  <= {CTRL_W{PIPE_CTRL_BUBBLE}};
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
         data  <= d_data;
      end else if (clr) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer (MAIN drives outputs,
// SKID catches the entry accepted while MAIN is stalled).
// Optional perf counters enabled by defining PIPE_PERF_EN.
// Ports:
//  CLK, nRST             clock, async active-low reset
//  flush                 sync flush: drops held entries and the current input
//  in_valid/in_ready     upstream handshake (in_ready is a flop output)
//  in_ctrl/in_data       upstream entry
//  out_valid/out_ready   downstream handshake
//  out_ctrl/out_data     MAIN entry (ctrl forced to 0 when out_valid=0)
//  stall_cnt/bubble_cnt  saturating perf counters, 0 without PIPE_PERF_EN
//
// state | meaning
// EMPTY | no slot valid
// ONE   | MAIN valid, SKID empty
// FULL  | MAIN and SKID valid, in_ready low
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 256,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   pipe_state_t       state;
   logic              main_valid, skid_valid;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
   logic [DATA_W-1:0] main_data, skid_data, main_d_data;
   logic              main_load, main_from_skid, main_clr;
   logic              skid_load, skid_clr;
   logic              acc, pop;

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign acc       = in_valid & in_ready;
   assign pop       = main_valid & out_ready;

   always_comb begin
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_clr       = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      case (state)
         EMPTY: main_load = acc;
         ONE: begin
            main_load = acc & pop;
            skid_load = acc & !pop;
            main_clr  = pop & !acc;
         end
         FULL: begin
            main_load      = pop;
            main_from_skid = pop;
            skid_clr       = pop;
         end
         default: ;
      endcase
   end

   assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_d_data = main_from_skid ? skid_data : in_data;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= EMPTY;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: if (acc) state <= ONE;
            ONE: begin
               if (acc && !pop)      state <= FULL;
               else if (pop && !acc) state <= EMPTY;
            end
            FULL: if (pop) state <= ONE;
            default: state <= EMPTY;
         endcase
      end
   end

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .CLK    (CLK),
      .nRST   (nRST),
      .flush  (flush),
      .load   (main_load),
      .clr    (main_clr),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .valid  (main_valid),
      .ctrl   (main_ctrl),
      .data   (main_data)
   );

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .CLK    (CLK),
      .nRST   (nRST),
      .flush  (flush),
      .load   (skid_load),
      .clr    (skid_clr),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
   );

   // MAIN ctrl keeps its last value after a plain pop, so gate it here.
   assign out_ctrl = main_valid ? main_ctrl : {CTRL_W{PIPE_CTRL_BUBBLE}};
   assign out_data = main_data;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_q, bubble_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (main_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (!main_valid && !(&bubble_q))             bubble_q <= bubble_q + CNT_W'(1);
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   logic         CLK = 1'b0;
   logic         nRST = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [15:0]  in_ctrl = '0;
   logic [255:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [15:0]  out_ctrl;
   logic [255:0] out_data;
   logic [3:0]   stall_cnt, bubble_cnt;

   pipe_stage_skid #(.CTRL_W(16), .DATA_W(256), .CNT_W(4)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // scoreboard of accepted-but-not-consumed ctrl words, oldest first
   logic [15:0] mq[$];
   logic [3:0]  m_stall = '0;
   logic [3:0]  m_bubble = '0;

   typedef struct {
      logic        v;
      logic        r;
      logic        f;
      logic [15:0] c;
      logic        ov;
      logic        ir;
      logic [15:0] oc;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic pop, acc;
`ifdef PIPE_PERF_EN
      if (mq.size() == 0) begin
         if (m_bubble != 4'hF) m_bubble++;
      end else if (!out_ready && m_stall != 4'hF) begin
         m_stall++;
      end
`endif
      if (flush) begin
         mq.delete();
      end else begin
         pop = (mq.size() > 0) && out_ready;
         acc = in_valid && (mq.size() < 2);
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(in_ctrl);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, " out_valid"}, out_valid, mq.size() > 0);
      chk({tag, " in_ready"}, in_ready, mq.size() < 2);
      chk({tag, " out_ctrl"}, out_ctrl, (mq.size() > 0) ? mq[0] : 16'h0);
      if (mq.size() > 0) chk({tag, " out_data"}, out_data, {16{mq[0]}});
      chk({tag, " stall_cnt"}, stall_cnt, m_stall);
      chk({tag, " bubble_cnt"}, bubble_cnt, m_bubble);
   endtask

   task automatic cycle(input logic v, input logic r, input logic f, input logic [15:0] c);
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_ctrl   = c;
      in_data   = {16{c}};
      @(posedge CLK);
      model_step();
      #1;
      check_model("model");
   endtask

   task automatic add(input logic v, input logic r, input logic f, input logic [15:0] c,
                      input logic ov, input logic ir, input logic [15:0] oc);
      vec_t e;
      e.v = v; e.r = r; e.f = f; e.c = c; e.ov = ov; e.ir = ir; e.oc = oc;
      tbl.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " out_valid"}, out_valid, 1'b0);
      chk({tag, " in_ready"}, in_ready, 1'b1);
      chk({tag, " out_ctrl"}, out_ctrl, 16'h0);
      chk({tag, " out_data"}, out_data, 256'h0);
      chk({tag, " stall_cnt"}, stall_cnt, 4'h0);
      chk({tag, " bubble_cnt"}, bubble_cnt, 4'h0);
   endtask

   task automatic enter_reset();
      nRST = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      mq.delete();
      m_stall = '0;
      m_bubble = '0;
   endtask

   initial begin
      // streaming, 1-cycle latency
      for (int i = 1; i <= 8; i++) add(1, 1, 0, 16'(i), 1, 1, 16'(i));
      add(0, 1, 0, 16'h0, 0, 1, 16'h0);
      // stall with skid: A, B accepted, C held upstream
      add(1, 0, 0, 16'h000A, 1, 1, 16'h000A);
      add(1, 0, 0, 16'h000B, 1, 0, 16'h000A);
      add(1, 0, 0, 16'h000C, 1, 0, 16'h000A);
      add(1, 1, 0, 16'h000C, 1, 1, 16'h000B);
      add(1, 1, 0, 16'h000C, 1, 1, 16'h000C);
      add(0, 1, 0, 16'h0000, 0, 1, 16'h0000);
      // flush in FULL with an input presented
      add(1, 0, 0, 16'h000D, 1, 1, 16'h000D);
      add(1, 0, 0, 16'h000E, 1, 0, 16'h000D);
      add(1, 0, 1, 16'h00FF, 0, 1, 16'h0000);
      add(0, 1, 0, 16'h0000, 0, 1, 16'h0000);
      add(0, 1, 0, 16'h0000, 0, 1, 16'h0000);
      // flush together with a pop in ONE
      add(1, 0, 0, 16'h0011, 1, 1, 16'h0011);
      add(0, 1, 1, 16'h0000, 0, 1, 16'h0000);
      add(0, 1, 0, 16'h0000, 0, 1, 16'h0000);

      enter_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_reset_outputs("por");
      nRST = 1'b1;

      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].c);
         chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
         chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].ir);
         chk($sformatf("vec%0d out_ctrl", i), out_ctrl, tbl[i].oc);
         if (tbl[i].ov) chk($sformatf("vec%0d out_data", i), out_data, {16{tbl[i].oc}});
      end

      // reset mid-stream while FULL
      cycle(1, 0, 0, 16'h0021);
      cycle(1, 0, 0, 16'h0022);
      chk("full in_ready", in_ready, 1'b0);
      enter_reset();
      #2;
      check_reset_outputs("async rst");
      @(posedge CLK);
      #1;
      check_reset_outputs("rst next");
      // first acceptance on the first edge after release
      nRST = 1'b1;
      cycle(1, 1, 0, 16'h0031);
      chk("post rst first acc", out_ctrl, 16'h0031);
      cycle(0, 1, 0, 16'h0000);

      // perf counters from a clean reset
      enter_reset();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      cycle(0, 0, 0, 16'h0000);
      cycle(0, 0, 0, 16'h0000);
      cycle(1, 0, 0, 16'h0041);
      repeat (5) cycle(0, 0, 0, 16'h0000);
`ifdef PIPE_PERF_EN
      chk("stall 5", stall_cnt, 4'd5);
      chk("bubble 3", bubble_cnt, 4'd3);
`else
      chk("stall off", stall_cnt, 4'd0);
      chk("bubble off", bubble_cnt, 4'd0);
`endif
      repeat (20) cycle(0, 0, 0, 16'h0000);
`ifdef PIPE_PERF_EN
      chk("stall sat", stall_cnt, 4'd15);
      chk("bubble hold", bubble_cnt, 4'd3);
`else
      chk("stall sat off", stall_cnt, 4'd0);
`endif
      // flush leaves counters alone
      cycle(0, 1, 1, 16'h0000);
      chk("flush keeps cnt", stall_cnt, m_stall);

      // random traffic against the scoreboard
      for (int n = 0; n < 300; n++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 19) == 0), 16'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
